// File: rtl/uart_mmio.sv
// uart_mmio - memory-mapped 8N1 UART for the CPU character I/O window.
//
// Register map (byte addresses):
//   0x082 DATA   write: push wr_data[7:0] into the 4-entry TX FIFO
//                read : {rx_valid, 7'b0, rx_byte} (0x0000 when empty), clears rx_valid
//   0x084 STATUS read : {10'b0, tx_ovr, frame_err, rx_ovr, rx_valid, tx_busy, tx_full}
//                       clears tx_ovr, frame_err and rx_ovr
//
// Ports:
//   clk      core clock, rising edge
//   rst      asynchronous reset, active low
//   addr     CPU byte address (ADDR_WIDTH bits)
//   wr       write strobe
//   rd       read strobe, one cycle per CPU load
//   wr_data  write data, only [7:0] used
//   rd_data  registered read data, valid the cycle after rd
//   tx       serial output, idle high
//   rx       serial input, asynchronous to clk
//
// Build option: define UART_LOOPBACK_EN to feed the RX synchronizer from the
// internal tx line instead of the rx pin.
module uart_mmio #(
  parameter int CLOCK_HZ   = 27_000_000,
  parameter int BAUD       = 115_200,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [15:0]           wr_data,
  output logic [15:0]           rd_data,
  output logic                  tx,
  input  logic                  rx
);

  localparam int DIV = CLOCK_HZ / BAUD;
  localparam int CW  = $clog2(DIV) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_DATA = ADDR_WIDTH'(12'h082);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STAT = ADDR_WIDTH'(12'h084);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Bus decode
  logic w_data_wr, w_data_rd, w_stat_rd;
  assign w_data_wr = wr && (addr == ADDR_DATA);
  assign w_data_rd = rd && (addr == ADDR_DATA);
  assign w_stat_rd = rd && (addr == ADDR_STAT);

  // TX FIFO state
  logic [7:0] r_fifo [0:3];
  logic [1:0] r_wptr, r_rptr;
  logic [2:0] r_count;
  logic       w_tx_full, w_tx_empty, w_push, w_pop;

  // TX shifter state
  state_t      r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_tx;

  assign w_tx_full  = (r_count == 3'd4);
  assign w_tx_empty = (r_count == 3'd0);
  // A full FIFO drops the write even if the shifter pops this cycle.
  assign w_push     = w_data_wr && !w_tx_full;
  // The shifter takes a byte from IDLE, or at the end of STOP for gapless frames.
  assign w_pop      = !w_tx_empty &&
                      ((r_tx_state == S_IDLE) ||
                       ((r_tx_state == S_STOP) && (r_tx_cnt == CNT_LAST)));

  // TX FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_fifo[i] <= 8'h00;
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= wr_data[7:0];
        r_wptr         <= r_wptr + 2'd1;
      end
      if (w_pop) r_rptr <= r_rptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // TX FSM with registered serial output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          if (!w_tx_empty) begin
            r_tx_shift <= r_fifo[r_rptr];
            r_tx       <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_state <= S_START;
          end
        end
        S_START: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx       <= r_tx_shift[0];
            r_tx_state <= S_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx       <= 1'b1;
              r_tx_state <= S_STOP;
            end else begin
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx       <= r_tx_shift[1];
              r_tx_bit   <= r_tx_bit + 3'd1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt <= '0;
            if (!w_tx_empty) begin
              r_tx_shift <= r_fifo[r_rptr];
              r_tx       <= 1'b0;
              r_tx_state <= S_START;
            end else begin
              r_tx_state <= S_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_ONE;
          end
        end
        default: begin
          r_tx_state <= S_IDLE;
          r_tx       <= 1'b1;
        end
      endcase
    end
  end

  assign tx = r_tx;

  // RX input selection and synchronizer
  logic w_rx_in, w_unused;
`ifdef UART_LOOPBACK_EN
  assign w_rx_in  = r_tx;
  assign w_unused = ^{wr_data[15:8], rx};
`else
  assign w_rx_in  = rx;
  assign w_unused = ^wr_data[15:8];
`endif

  logic r_sync1, r_sync2;

  // Two-flop synchronizer, idles high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= w_rx_in;
      r_sync2 <= r_sync1;
    end
  end

  state_t      r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        w_rx_done, w_rx_ferr;

  assign w_rx_done = (r_rx_state == S_STOP) && (r_rx_cnt == CNT_LAST) && r_sync2;
  assign w_rx_ferr = (r_rx_state == S_STOP) && (r_rx_cnt == CNT_LAST) && !r_sync2;

  // RX FSM: samples mid-bit, LSB first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      case (r_rx_state)
        S_IDLE: begin
          if (!r_sync2) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_START;
          end
        end
        S_START: begin
          if (r_rx_cnt == CNT_HALF) begin
            r_rx_cnt <= '0;
            r_rx_bit <= 3'd0;
            // A high line at mid-start-bit means the low was a glitch.
            r_rx_state <= r_sync2 ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (r_rx_cnt == CNT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_sync2, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (r_rx_cnt == CNT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_ONE;
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  logic        r_rx_valid, r_rx_ovr, r_frame_err, r_tx_ovr;
  logic [7:0]  r_rx_byte;
  logic [15:0] r_rd_data;
  logic [15:0] w_status;
  logic        w_tx_busy;

  assign w_tx_busy = !w_tx_empty || (r_tx_state != S_IDLE);
  assign w_status  = {10'b0, r_tx_ovr, r_frame_err, r_rx_ovr, r_rx_valid, w_tx_busy, w_tx_full};

  // Holding register, sticky flags and registered read data.
  // Flag sets take priority over read-clears in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_valid  <= 1'b0;
      r_rx_byte   <= 8'h00;
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_ovr    <= 1'b0;
      r_rd_data   <= 16'h0000;
    end else begin
      if (w_rx_done) begin
        r_rx_byte  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_data_rd) begin
        r_rx_valid <= 1'b0;
      end
      // A completion racing a DATA read is not an overrun: the old byte is consumed.
      if (w_rx_done && r_rx_valid && !w_data_rd) r_rx_ovr <= 1'b1;
      else if (w_stat_rd)                        r_rx_ovr <= 1'b0;
      if (w_rx_ferr)      r_frame_err <= 1'b1;
      else if (w_stat_rd) r_frame_err <= 1'b0;
      if (w_data_wr && w_tx_full) r_tx_ovr <= 1'b1;
      else if (w_stat_rd)         r_tx_ovr <= 1'b0;
      if (w_data_rd)      r_rd_data <= r_rx_valid ? {1'b1, 7'b0, r_rx_byte} : 16'h0000;
      else if (w_stat_rd) r_rd_data <= w_status;
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio - directed self-checking bench for uart_mmio at DIV = 4
// (CLOCK_HZ = 400, BAUD = 100). Inputs change on the falling edge and
// outputs are sampled on the falling edge.
module tb_uart_mmio;

  localparam int DIV = 4;
  localparam logic [15:0] A_DATA = 16'h0082;
  localparam logic [15:0] A_STAT = 16'h0084;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic [15:0] rd_data;
  logic        tx;
  logic        rx = 1'b1;

  logic [15:0] d;
  logic        seen_low;
  logic [7:0]  b;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  uart_mmio #(.CLOCK_HZ(400), .BAUD(100), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd),
    .wr_data(wr_data), .rd_data(rd_data), .tx(tx), .rx(rx)
  );

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] v);
    @(negedge clk);
    addr = a; wr_data = v; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    v = rd_data;
  endtask

  task automatic send_rx(input logic [7:0] byte_v, input logic stop_v);
    logic [9:0] f;
    f = {stop_v, byte_v, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  // Expected tx level for a given cycle slot within a 10-bit frame
  function automatic logic frame_bit(input logic [7:0] byte_v, input int slot);
    logic [9:0] f;
    f = {1'b1, byte_v, 1'b0};
    return f[slot / DIV];
  endfunction

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_tx", {15'b0, tx}, 16'h0001);
    check_eq("rst_rd_data", rd_data, 16'h0000);
    rst = 1'b1;
    bus_read(A_STAT, d);
    check_eq("status_after_rst", d, 16'h0000);

`ifdef UART_LOOPBACK_EN
    bus_write(A_DATA, 16'h003C);
    repeat (50) @(negedge clk);
    bus_read(A_DATA, d);
    check_eq("loopback_data", d, 16'h803C);
    bus_read(A_DATA, d);
    check_eq("loopback_empty", d, 16'h0000);
    bus_read(A_STAT, d);
    check_eq("loopback_status", d, 16'h0000);
`else
    // Single frame 0x55 with busy seen mid-frame
    bus_write(A_DATA, 16'h0055);
    for (int c = 0; c < 10 * DIV; c++) begin
      @(negedge clk);
      check_eq("tx_frame55", {15'b0, tx}, {15'b0, frame_bit(8'h55, c)});
      if (c == 8) begin
        addr = A_STAT; rd = 1'b1;
      end else begin
        rd = 1'b0;
      end
      if (c == 9) check_eq("busy_during", {15'b0, rd_data[1]}, 16'h0001);
    end
    @(negedge clk);
    bus_read(A_STAT, d);
    check_eq("status_idle_after55", d, 16'h0000);

    // Six back-to-back writes: one goes straight to the shifter, four fill
    // the FIFO, the sixth is dropped.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      addr = A_DATA; wr_data = 16'h0041 + 16'(i); wr = 1'b1;
    end
    @(negedge clk);
    wr = 1'b0; addr = A_STAT; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check_eq("status_full_ovr", rd_data, 16'h0023);
    for (int c = 6; c < 50 * DIV; c++) begin
      @(negedge clk);
      b = 8'h41 + 8'(c / (10 * DIV));
      check_eq("tx_burst", {15'b0, tx}, {15'b0, frame_bit(b, c % (10 * DIV))});
    end
    bus_read(A_STAT, d);
    check_eq("status_after_burst", d, 16'h0000);
    repeat (10) @(negedge clk);
    check_eq("tx_idle_after_burst", {15'b0, tx}, 16'h0001);

    // Receive 0xA3
    send_rx(8'hA3, 1'b1);
    repeat (2) @(negedge clk);
    bus_read(A_STAT, d);
    check_eq("status_rx_valid", d, 16'h0004);
    bus_read(16'h0080, d);
    check_eq("undecoded_read_keeps", d, 16'h0004);
    bus_read(A_DATA, d);
    check_eq("rx_data_A3", d, 16'h80A3);
    bus_read(A_DATA, d);
    check_eq("rx_data_empty", d, 16'h0000);

    // Overrun: 0x11 then 0x22 without reading
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    bus_read(A_DATA, d);
    check_eq("rx_data_22", d, 16'h8022);
    bus_read(A_STAT, d);
    check_eq("status_rx_ovr", d, 16'h0008);
    bus_read(A_STAT, d);
    check_eq("status_ovr_cleared", d, 16'h0000);

    // Framing error
    send_rx(8'h5A, 1'b0);
    repeat (2) @(negedge clk);
    bus_read(A_STAT, d);
    check_eq("status_frame_err", d, 16'h0010);
    bus_read(A_DATA, d);
    check_eq("ferr_no_data", d, 16'h0000);

    // One-cycle glitch
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    bus_read(A_STAT, d);
    check_eq("glitch_status", d, 16'h0000);
    bus_read(A_DATA, d);
    check_eq("glitch_data", d, 16'h0000);
`endif

    // Undecoded write must not start a frame
    bus_write(16'h0083, 16'h0077);
    repeat (2) @(negedge clk);
    check_eq("undecoded_write_tx", {15'b0, tx}, 16'h0001);
    bus_read(A_STAT, d);
    check_eq("undecoded_write_status", d, 16'h0000);

    // Reset in the middle of a frame with a byte still queued
    bus_write(A_DATA, 16'h0055);
    bus_write(A_DATA, 16'h000F);
    repeat (8) @(negedge clk);
    check_eq("tx_before_rst", {15'b0, tx}, 16'h0000);
    #1 rst = 1'b0;
    #1;
    check_eq("tx_async_rst", {15'b0, tx}, 16'h0001);
    check_eq("rd_data_async_rst", rd_data, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    seen_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx == 1'b0) seen_low = 1'b1;
    end
    check_eq("no_tx_after_rst", {15'b0, seen_low}, 16'h0000);
    bus_read(A_STAT, d);
    check_eq("status_after_mid_rst", d, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
